// File: rtl/mem_stage_sram.sv
// MEM stage: external-SRAM controller (32-bit words split into SRAM_DW beats) plus the MEM/WB register.
// Define MEM_STATS_EN to add the stall_cycles / access_count statistics ports.
module mem_stage_sram #(
    parameter int SRAM_AW     = 18,
    parameter int SRAM_DW     = 16,
    parameter int WAIT_STATES = 3,
    parameter int BASE_ADDR   = 1024
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wb_en_in,
    input  logic               mem_r_en_in,
    input  logic               mem_w_en_in,
    input  logic [31:0]        alu_res_in,
    input  logic [31:0]        val_rm_in,
    input  logic [3:0]         dest_in,
    output logic               freeze,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [SRAM_DW-1:0] sram_dq_out,
    input  logic [SRAM_DW-1:0] sram_dq_in,
    output logic               sram_dq_oe,
    output logic               sram_we_n,
    output logic               wb_en_out,
    output logic               mem_r_en_out,
    output logic [31:0]        alu_res_out,
    output logic [31:0]        mem_data_out,
    output logic [3:0]         dest_out
`ifdef MEM_STATS_EN
    ,
    output logic [31:0]        stall_cycles,
    output logic [31:0]        access_count
`endif
);
    localparam int BEATS  = 32 / SRAM_DW;
    localparam int WAIT_W = $clog2(WAIT_STATES);
    localparam logic [1:0]        LAST_BEAT = 2'(BEATS - 1);
    localparam logic [WAIT_W-1:0] LAST_WAIT = WAIT_W'(WAIT_STATES - 1);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t            state_q, state_d;
    logic [1:0]        beat_q, beat_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [31:0]       word_q;
    logic [31:0]       wrData_q;
    logic [31:0]       rdData_q;
    logic              isStore_q;
    logic              isLoad_q;
    logic              wbEn_q;
    logic [3:0]        dest_q;
    logic [31:0]       aluRes_q;

    logic              wbEnOut_q;
    logic              memREnOut_q;
    logic [31:0]       aluResOut_q;
    logic [31:0]       memDataOut_q;
    logic [3:0]        destOut_q;

    logic              req;
    logic              lastWait;
    logic              lastBeat;
    logic [5:0]        shiftAmt;

    assign req      = mem_r_en_in | mem_w_en_in;
    assign lastWait = (wait_q == LAST_WAIT);
    assign lastBeat = (beat_q == LAST_BEAT);
    assign shiftAmt = 6'(beat_q) * 6'(SRAM_DW);
    assign freeze   = req & (state_q != DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            beat_q  <= '0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            wait_q  <= wait_d;
        end
    end

    // Each beat spends WAIT_STATES cycles on the bus; the write strobe is released on the
    // last cycle so address and data are held stable past the rising edge of we_n.
    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        wait_d      = wait_q;
        sram_addr   = '0;
        sram_dq_out = '0;
        sram_dq_oe  = 1'b0;
        sram_we_n   = 1'b1;
        case (state_q)
            IDLE: begin
                if (req) begin
                    state_d = ACCESS;
                    beat_d  = '0;
                    wait_d  = '0;
                end
            end
            ACCESS: begin
                sram_addr = SRAM_AW'(word_q * 32'(BEATS) + 32'(beat_q));
                if (isStore_q) begin
                    sram_dq_oe  = 1'b1;
                    sram_dq_out = SRAM_DW'(wrData_q >> shiftAmt);
                    sram_we_n   = lastWait;
                end
                if (lastWait) begin
                    wait_d = '0;
                    if (lastBeat) begin
                        state_d = DONE;
                    end else begin
                        beat_d = beat_q + 2'd1;
                    end
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            word_q    <= '0;
            wrData_q  <= '0;
            rdData_q  <= '0;
            isStore_q <= 1'b0;
            isLoad_q  <= 1'b0;
            wbEn_q    <= 1'b0;
            dest_q    <= '0;
            aluRes_q  <= '0;
        end else if (state_q == IDLE && req) begin
            word_q    <= (alu_res_in - 32'(BASE_ADDR)) >> 2;
            wrData_q  <= val_rm_in;
            rdData_q  <= '0;
            isStore_q <= mem_w_en_in;
            isLoad_q  <= mem_r_en_in;
            wbEn_q    <= wb_en_in;
            dest_q    <= dest_in;
            aluRes_q  <= alu_res_in;
        end else if (state_q == ACCESS && !isStore_q && lastWait) begin
            rdData_q  <= rdData_q | (32'(sram_dq_in) << shiftAmt);
        end
    end

    // MEM/WB: a bubble while frozen, the latched access in DONE, otherwise straight pass-through.
    always_ff @(posedge clk) begin
        if (rst) begin
            wbEnOut_q    <= 1'b0;
            memREnOut_q  <= 1'b0;
            aluResOut_q  <= '0;
            memDataOut_q <= '0;
            destOut_q    <= '0;
        end else if (freeze) begin
            wbEnOut_q    <= 1'b0;
            memREnOut_q  <= 1'b0;
        end else if (state_q == DONE) begin
            wbEnOut_q    <= wbEn_q;
            memREnOut_q  <= isLoad_q;
            aluResOut_q  <= aluRes_q;
            memDataOut_q <= isStore_q ? 32'h0 : rdData_q;
            destOut_q    <= dest_q;
        end else begin
            wbEnOut_q    <= wb_en_in;
            memREnOut_q  <= mem_r_en_in;
            aluResOut_q  <= alu_res_in;
            memDataOut_q <= '0;
            destOut_q    <= dest_in;
        end
    end

    assign wb_en_out    = wbEnOut_q;
    assign mem_r_en_out = memREnOut_q;
    assign alu_res_out  = aluResOut_q;
    assign mem_data_out = memDataOut_q;
    assign dest_out     = destOut_q;

`ifdef MEM_STATS_EN
    logic [31:0] stallCycles_q;
    logic [31:0] accessCount_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stallCycles_q <= '0;
            accessCount_q <= '0;
        end else begin
            if (freeze) begin
                stallCycles_q <= stallCycles_q + 32'd1;
            end
            if (state_q == DONE) begin
                accessCount_q <= accessCount_q + 32'd1;
            end
        end
    end

    assign stall_cycles = stallCycles_q;
    assign access_count = accessCount_q;
`endif

endmodule

// File: doc/mem_stage_sram.md
# mem_stage_sram

Parametrised MEM stage of the ARM pipeline, replacing the single-cycle data memory with an external-SRAM controller plus the MEM/WB pipeline register. It accepts the EXE/MEM register outputs and splits each 32-bit word access into SRAM-width beats with a configurable number of wait cycles per beat. While an access is in flight it raises `freeze` to hold the upstream stages, inserts bubbles into WB, and registers the result for write-back when the access completes.

## Interface
- `SRAM_AW`, 18, SRAM address width (beat-granular).
- `SRAM_DW`, 16, SRAM data width; legal values are 8, 16, 32. BEATS = 32/SRAM_DW.
- `WAIT_STATES`, 3, cycles per beat; minimum 2.
- `BASE_ADDR`, 1024, byte address that maps to SRAM word 0.

Ports:
- `clk  in  1  clock`; one clock, all logic on its rising edge.
- `rst  in  1  reset`; synchronous, active-high.
- `wb_en_in  in  1  write-back enable from EXE/MEM register`
- `mem_r_en_in  in  1  load request`
- `mem_w_en_in  in  1  store request`
- `alu_res_in  in  32  byte address (memory ops) or ALU result`
- `val_rm_in  in  32  store data`
- `dest_in  in  4  destination register`
- `freeze  out  1  stall request to IF/ID/EXE and their registers`
- `sram_addr  out  SRAM_AW  beat address`
- `sram_dq_out  out  SRAM_DW  write data`
- `sram_dq_in  in  SRAM_DW  read data`
- `sram_dq_oe  out  1  drive enable for data bus (1 on writes)`
- `sram_we_n  out  1  active-low write strobe`
- `wb_en_out  out  1  MEM/WB write-back enable`
- `mem_r_en_out  out  1  MEM/WB load select`
- `alu_res_out  out  32  MEM/WB ALU result`
- `mem_data_out  out  32  MEM/WB load data`
- `dest_out  out  4  MEM/WB destination`

## Operation
- Request: `req = mem_r_en_in | mem_w_en_in`. If both are set, the op is treated as a store and `mem_data_out` is 0.
- Word address: `(alu_res_in - BASE_ADDR) >> 2`. Beat address: `word*BEATS + beat`, truncated modulo 2^SRAM_AW. Out-of-range addresses wrap silently.
- FSM states:
  - IDLE: when `req`, latch address, data, type, wb_en and dest; clear the beat and wait counters; go to ACCESS.
  - ACCESS: `sram_addr` shows the current beat.
    - Stores: `sram_dq_oe=1`; `sram_dq_out` = beat slice (beat 0 = bits [SRAM_DW-1:0]); `sram_we_n=0` for wait counts 0..WAIT_STATES-2 and 1 on the last cycle (address/data hold).
    - Loads: `sram_dq_in` is sampled on the last cycle of each beat into that beat's slice.
    - After the last cycle of the last beat, go to DONE.
  - DONE: one cycle, then IDLE.
- Inputs are ignored while in ACCESS or DONE; only the values latched in IDLE are used.
- `freeze = req & (state != DONE)` (combinational). It is high from the request cycle through the last ACCESS cycle.
- MEM/WB register:
  - When `freeze=0`: load `wb_en`, `mem_r_en`, `alu_res`, `dest`, plus `mem_data` (the latched read buffer in DONE, otherwise 0).
  - When `freeze=1`: load a bubble (`wb_en_out=0`, `mem_r_en_out=0`; other fields hold).
- Non-memory ops pass through with 1-cycle latency and no freeze.
- Reset (including mid-access): state IDLE; counters 0; `sram_we_n=1`, `sram_dq_oe=0`, `sram_addr=0`, `sram_dq_out=0`; all MEM/WB outputs 0; `freeze` low once `req` is low.

## Timing
- Memory op latency, request cycle to MEM/WB valid: BEATS*WAIT_STATES+2 edges.
- `freeze` high for BEATS*WAIT_STATES+1 cycles (IDLE request cycle + ACCESS), low in DONE.
- Back-to-back memory ops: the next request is seen in the cycle after DONE (IDLE), so one non-frozen cycle separates accesses.
- Non-memory op: MEM/WB valid on the next edge.

## Configuration
- `MEM_STATS_EN` defined: adds `stall_cycles out 32` (increments each cycle `freeze=1`) and `access_count out 32` (increments on each DONE). Both reset to 0 and wrap at 2^32.
- `MEM_STATS_EN` undefined: these ports and counters do not exist; behaviour is otherwise identical.

## Test plan
- SRAM_DW=16, WAIT_STATES=3, store 0xDEADBEEF to byte addr 1032 -> beats at sram_addr 4 (0xBEEF) and 5 (0xDEAD); `sram_we_n` low 2 cycles per beat; `freeze` high 7 cycles; `wb_en_out`=0 throughout.
- Load 1032 after the above, with dest 5 and wb_en 1 -> `mem_data_out`=0xDEADBEEF, `mem_r_en_out`=1, `dest_out`=5, 8 edges after request.
- Non-memory op, alu_res 0x12345678 with wb_en 1 -> `alu_res_out`=0x12345678 next cycle; `freeze` never asserted.
- `rst` asserted during beat 1 of a store -> next cycle IDLE, `sram_we_n`=1, `sram_dq_oe`=0, all outputs 0.
- SRAM_DW=32, WAIT_STATES=2, load from 1024 with `sram_dq_in`=0xCAFEF00D -> single beat at addr 0, `freeze` high 3 cycles, data 0xCAFEF00D.
- With `MEM_STATS_EN`: two 16-bit stores at WAIT_STATES=3 -> `access_count`=2, `stall_cycles`=14.
